// File: rtl/la_aoi33_bist.sv
// Built-in self test for an external AOI33 cell: walks all 64 input patterns,
// compares the returned z against the ideal function and reports the results.
module la_aoi33_bist #(
    parameter        PROP   = "DEFAULT",
    parameter int    SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] drive,
    input  logic       z_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic [5:0] first_fail,
    output logic       first_fail_vld
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("la_aoi33_bist: SETTLE must be in 1..255");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic aoi33(input logic [5:0] p);
        return ~((p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]));
    endfunction

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [5:0] drive_s;
    logic       busy_s, done_s, pass_s;
    logic [6:0] err_count_s;
    logic [5:0] first_fail_s;
    logic       first_fail_vld_s;
    logic       mismatch_s;
    logic [6:0] err_upd_s;

    // Next-state and next-output logic for the pattern walker.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        drive_s          = drive;
        busy_s           = busy;
        done_s           = done;
        pass_s           = pass;
        err_count_s      = err_count;
        first_fail_s     = first_fail;
        first_fail_vld_s = first_fail_vld;

        mismatch_s = (z_in != aoi33(drive));
        if (mismatch_s && (err_count != 7'd64)) begin
            err_upd_s = err_count + 7'd1;
        end else begin
            err_upd_s = err_count;
        end

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s          = S_SETTLE;
                    cnt_s            = 8'd0;
                    drive_s          = 6'd0;
                    busy_s           = 1'b1;
                    done_s           = 1'b0;
                    pass_s           = 1'b0;
                    err_count_s      = 7'd0;
                    first_fail_s     = 6'd0;
                    first_fail_vld_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            S_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = S_CHECK;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            S_CHECK: begin
                err_count_s = err_upd_s;
                if (mismatch_s && !first_fail_vld) begin
                    first_fail_s     = drive;
                    first_fail_vld_s = 1'b1;
                end else begin
                    first_fail_vld_s = first_fail_vld;
                end
                // Pass is judged on the count including pattern 63's own result.
                if (drive == 6'd63) begin
                    state_s = S_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_upd_s == 7'd0);
                end else begin
                    state_s = S_SETTLE;
                    cnt_s   = 8'd0;
                    drive_s = drive + 6'd1;
                end
            end
            default: begin
                state_s          = S_IDLE;
                cnt_s            = 8'd0;
                drive_s          = 6'd0;
                busy_s           = 1'b0;
                done_s           = 1'b0;
                pass_s           = 1'b0;
                err_count_s      = 7'd0;
                first_fail_s     = 6'd0;
                first_fail_vld_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            cnt_r          <= 8'd0;
            drive          <= 6'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 7'd0;
            first_fail     <= 6'd0;
            first_fail_vld <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            drive          <= drive_s;
            busy           <= busy_s;
            done           <= done_s;
            pass           <= pass_s;
            err_count      <= err_count_s;
            first_fail     <= first_fail_s;
            first_fail_vld <= first_fail_vld_s;
        end
    end

endmodule

// File: tb/tb_la_aoi33_bist.sv
// Self-checking bench for la_aoi33_bist: table of cell fault modes with a
// result scoreboard, plus sequences for held start, mid-run reset and rerun.
module tb_la_aoi33_bist;

    localparam int SETTLE  = 2;
    localparam int RUN_LEN = 64 * (SETTLE + 1);

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] drive;
    logic       z_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [5:0] first_fail;
    logic       first_fail_vld;

    // 0 ideal, 1 stuck-0, 2 stuck-1, 3 wrong only at 63, 4 wrong at 5 and 40
    int mode;

    int n_checks;
    int n_fail;

    typedef struct {
        int mode;
        int exp_err;
        int exp_ff;
        int exp_ffv;
        int exp_pass;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];

    la_aoi33_bist #(.PROP("DEFAULT"), .SETTLE(SETTLE)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .drive          (drive),
        .z_in           (z_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the cell under test, with injectable faults.
    always_comb begin
        logic ideal;
        ideal = ~((drive[0] & drive[1] & drive[2]) | (drive[3] & drive[4] & drive[5]));
        case (mode)
            1:       z_in = 1'b0;
            2:       z_in = 1'b1;
            3:       z_in = ideal ^ (drive == 6'd63);
            4:       z_in = ideal ^ ((drive == 6'd5) || (drive == 6'd40));
            default: z_in = ideal;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for done after an accept edge; returns cycles taken and whether busy dropped early.
    task automatic wait_done(output int cycles, output int busy_drop);
        cycles    = 0;
        busy_drop = 0;
        while (done !== 1'b1 && cycles < 1000) begin
            if (busy !== 1'b1) busy_drop = 1;
            tick();
            cycles++;
        end
    endtask

    task automatic check_accept();
        check("accept_busy", int'(busy), 1);
        check("accept_done", int'(done), 0);
        check("accept_pass", int'(pass), 0);
        check("accept_drive", int'(drive), 0);
        check("accept_err", int'(err_count), 0);
        check("accept_ff", int'(first_fail), 0);
        check("accept_ffv", int'(first_fail_vld), 0);
    endtask

    task automatic check_result();
        vec_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("res_err", int'(err_count), e.exp_err);
            check("res_ff", int'(first_fail), e.exp_ff);
            check("res_ffv", int'(first_fail_vld), e.exp_ffv);
            check("res_pass", int'(pass), e.exp_pass);
            check("res_drive", int'(drive), 63);
            check("res_busy", int'(busy), 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold_start);
        int cycles;
        int drop;
        mode  = v.mode;
        start = 1'b1;
        sb_q.push_back(v);
        tick();
        if (hold_start == 0) start = 1'b0;
        check_accept();
        wait_done(cycles, drop);
        check("run_latency", cycles, RUN_LEN);
        check("run_busy_held", drop, 0);
        check_result();
    endtask

    initial begin
        int cycles;
        int drop;
        n_checks = 0;
        n_fail   = 0;
        mode     = 0;
        reset    = 1'b1;
        start    = 1'b0;

        vecs[0] = '{mode: 0, exp_err: 0,  exp_ff: 0,  exp_ffv: 0, exp_pass: 1};
        vecs[1] = '{mode: 1, exp_err: 49, exp_ff: 0,  exp_ffv: 1, exp_pass: 0};
        vecs[2] = '{mode: 0, exp_err: 0,  exp_ff: 0,  exp_ffv: 0, exp_pass: 1};
        vecs[3] = '{mode: 2, exp_err: 15, exp_ff: 7,  exp_ffv: 1, exp_pass: 0};
        vecs[4] = '{mode: 3, exp_err: 1,  exp_ff: 63, exp_ffv: 1, exp_pass: 0};
        vecs[5] = '{mode: 4, exp_err: 2,  exp_ff: 5,  exp_ffv: 1, exp_pass: 0};

        tick();
        tick();
        reset = 1'b0;
        check("rst_drive", int'(drive), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_ffv", int'(first_fail_vld), 0);
        tick();
        tick();
        check("idle_drive", int'(drive), 0);
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 0);
            tick();
            tick();
            check("done_hold_done", int'(done), 1);
            check("done_hold_drive", int'(drive), 63);
            check("done_hold_err", int'(err_count), vecs[i].exp_err);
        end

        // Start held high: ignored mid-run, then re-accepted from DONE.
        run_vec(vecs[1], 1);
        tick();
        check("held_restart_busy", int'(busy), 1);
        check("held_restart_done", int'(done), 0);
        check("held_restart_err", int'(err_count), 0);
        start = 1'b0;

        // Reset in the middle of a failing run at pattern 20.
        cycles = 0;
        while (drive != 6'd20 && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("reach_pattern_20", int'(drive), 20);
        check("pre_reset_err_nonzero", int'(err_count != 7'd0), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_drive", int'(drive), 0);
        check("abort_err", int'(err_count), 0);
        check("abort_done", int'(done), 0);
        check("abort_ffv", int'(first_fail_vld), 0);
        tick();
        check("abort_stays_idle", int'(busy), 0);

        run_vec(vecs[0], 0);

        // A short start pulse mid-run must not restart the walk.
        mode  = 0;
        start = 1'b1;
        sb_q.push_back(vecs[0]);
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrun_start_ignored", int'(drive), 17);
        wait_done(cycles, drop);
        check("midrun_latency", cycles + 51, RUN_LEN);
        check_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/la_aoi33_bist.md
LA_AOI33_BIST -- requirements
Module: la_aoi33_bist

Interface
REQ-001 Parameter PROP, default "DEFAULT", implementation/property selector string, no functional effect.
REQ-002 Parameter SETTLE, default 2, settle cycles per pattern before sampling, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; level sampled each cycle.
REQ-006 drive  output  6  stimulus to cell under test, {b2,b1,b0,a2,a1,a0}.
REQ-007 z_in  input  1  returned z of the AOI33 cell under test.
REQ-008 busy  output  1  run in progress.
REQ-009 done  output  1  run complete; results valid.
REQ-010 pass  output  1  high only when done and err_count==0.
REQ-011 err_count  output  7  number of mismatching patterns, 0..64.
REQ-012 first_fail  output  6  first mismatching pattern value.
REQ-013 first_fail_vld  output  1  first_fail holds a captured pattern.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK, DONE.
REQ-015 start=1 in IDLE or DONE SHALL be accepted: next cycle state=SETTLE, drive=0, busy=1, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0.
REQ-016 start in SETTLE or CHECK SHALL be ignored.
REQ-017 SETTLE SHALL last exactly SETTLE cycles, then go to CHECK for exactly one cycle.
REQ-018 drive SHALL be registered and SHALL remain constant across a pattern's SETTLE and CHECK cycles.
REQ-019 At the edge ending CHECK, z_in SHALL be compared with expected = ~((p0&p1&p2)|(p3&p4&p5)), where p=drive.
REQ-020 On mismatch, err_count SHALL increment by 1 (no wrap: 64 is the maximum).
REQ-021 On the first mismatch of a run, first_fail SHALL take drive and first_fail_vld SHALL go to 1; later mismatches SHALL not change them.
REQ-022 CHECK with drive<63 SHALL set drive=drive+1 and return to SETTLE.
REQ-023 CHECK with drive==63 SHALL go to DONE with busy=0, done=1, and pass=(final err_count==0), including a mismatch found at pattern 63.
REQ-024 DONE SHALL hold done, pass, err_count, first_fail, first_fail_vld and drive=63 until start or reset.
REQ-025 The run SHALL enter DONE exactly 64*(SETTLE+1) cycles after the start-accept edge.
REQ-026 IDLE SHALL drive 0 with busy=0 and done=0.

Reset
REQ-027 reset=1 SHALL, at the next rising edge, set state=IDLE, drive=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0.
REQ-028 Reset SHALL take priority over start and over every FSM transition, including mid-run (run aborted, no results retained).
REQ-029 All outputs SHALL be register outputs with no combinational path from any input.

Verification
REQ-030 SETTLE=2, ideal AOI33 model on z_in, start pulse -> done=1 exactly 192 cycles after accept; pass=1, err_count=0, first_fail_vld=0.
REQ-031 z_in stuck at 0 -> err_count=49, first_fail=6'd0, first_fail_vld=1, pass=0.
REQ-032 z_in stuck at 1 -> err_count=15, first_fail=6'd7, pass=0.
REQ-033 start held high throughout a run -> no restart before DONE; busy stays 1 for the full 64*(SETTLE+1) cycles.
REQ-034 reset asserted while drive==20 -> next cycle busy=0, drive=0, err_count=0; a new start then runs all 64 patterns normally.
REQ-035 Failing run, then start from DONE with ideal model -> previous results cleared on accept; pass=1 at completion.
